// File: rtl/packet_credit_arbiter.sv
// Packet-locked round-robin arbiter sharing one output link among CHANNEL_NUMBER
// AXI-Stream ports, with TLAST framing and a downstream credit counter.
//
// state  | meaning
// IDLE   | no port owns the link; registering the round-robin selection
// LOCKED | current_grant owns the link until its TLAST flit is accepted
module packet_credit_arbiter #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int DATA_WIDTH           = 32,
  parameter int CREDITS              = 4,
  parameter int CREDIT_WIDTH         = $clog2(CREDITS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
  input  logic [CHANNEL_NUMBER-1:0]            in_tlast,
  output logic [CHANNEL_NUMBER-1:0]            in_tready,
  output logic                                 out_tvalid,
  output logic [DATA_WIDTH-1:0]                out_tdata,
  output logic                                 out_tlast,
  input  logic                                 out_tready,
  input  logic                                 credit_return,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]      current_grant,
  output logic                                 grant_valid,
  output logic [CREDIT_WIDTH-1:0]              credits_available,
  output logic                                 credit_overflow
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDITS);

  state_t                            state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0]   grant_q, grant_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0]           credits_q, credits_d;
  logic                              overflow_q, overflow_d;
  logic [CREDIT_WIDTH:0]             credit_sum;
  logic [2*CHANNEL_NUMBER-1:0]       req_dbl;
  logic [CHANNEL_NUMBER-1:0]         req_rot;
  logic [CHANNEL_NUMBER_WIDTH-1:0]   sel_idx;
  logic                              sel_found;
  logic                              credit_ok;
  logic                              xfer;

  assign credit_ok         = (credits_q != '0);
  assign xfer              = out_tvalid && out_tready;
  assign current_grant     = grant_q;
  assign grant_valid       = (state_q == LOCKED);
  assign credits_available = credits_q;
  assign credit_overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      credits_q  <= CREDIT_FULL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    req_dbl   = {in_tvalid, in_tvalid} >> rr_ptr_q;
    req_rot   = req_dbl[CHANNEL_NUMBER-1:0];
    sel_found = |req_rot;
    sel_idx   = '0;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        if (int'(rr_ptr_q) + k >= CHANNEL_NUMBER)
          sel_idx = CHANNEL_NUMBER_WIDTH'(int'(rr_ptr_q) + k - CHANNEL_NUMBER);
        else
          sel_idx = CHANNEL_NUMBER_WIDTH'(int'(rr_ptr_q) + k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCKED;
          grant_d = sel_idx;
        end
      end
      LOCKED: begin
        if (xfer && out_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ?
                     '0 : grant_q + CHANNEL_NUMBER_WIDTH'(1);
        end
      end
    endcase

    credit_sum = {1'b0, credits_q} + {{CREDIT_WIDTH{1'b0}}, credit_return}
                 - {{CREDIT_WIDTH{1'b0}}, xfer};
    credits_d  = credit_sum[CREDIT_WIDTH-1:0];
    overflow_d = overflow_q;
    if (credit_sum > {1'b0, CREDIT_FULL}) begin
      credits_d  = CREDIT_FULL;
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    in_tready  = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
        if (CHANNEL_NUMBER_WIDTH'(i) == grant_q) begin
          out_tvalid   = in_tvalid[i] && credit_ok;
          out_tdata    = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          out_tlast    = in_tlast[i];
          in_tready[i] = out_tready && credit_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_credit_arbiter.sv
// Directed bench for packet_credit_arbiter: arbitration order, packet locking,
// credit stall/return, overflow flag and mid-packet reset.
module tb_packet_credit_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_tvalid;
  logic [N*DW-1:0] in_tdata;
  logic [N-1:0]    in_tlast;
  logic [N-1:0]    in_tready;
  logic            out_tvalid;
  logic [DW-1:0]   out_tdata;
  logic            out_tlast;
  logic            out_tready;
  logic            credit_return;
  logic [2:0]      current_grant;
  logic            grant_valid;
  logic [2:0]      credits_available;
  logic            credit_overflow;

  int n_cmp = 0;
  int n_err = 0;

  packet_credit_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_tvalid         (in_tvalid),
    .in_tdata          (in_tdata),
    .in_tlast          (in_tlast),
    .in_tready         (in_tready),
    .out_tvalid        (out_tvalid),
    .out_tdata         (out_tdata),
    .out_tlast         (out_tlast),
    .out_tready        (out_tready),
    .credit_return     (credit_return),
    .current_grant     (current_grant),
    .grant_valid       (grant_valid),
    .credits_available (credits_available),
    .credit_overflow   (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int p, input int f);
    return 32'hC0DE_0000 | DW'(p << 8) | DW'(f);
  endfunction

  task automatic set_flit(input int f, input logic last);
    for (int p = 0; p < N; p++) in_tdata[p*DW +: DW] = dat(p, f);
    in_tlast = last ? 5'h1f : 5'h00;
  endtask

  // Called in IDLE; one arbitration bubble, then n contiguous flits from port.
  task automatic pkt(input int port, input int n, input logic ret, input logic [N-1:0] mask);
    in_tvalid     = mask;
    credit_return = 1'b0;
    set_flit(0, n == 1);
    #1;
    check("idle_gv", grant_valid, 0);
    check("idle_ov", out_tvalid, 0);
    check("idle_rdy", in_tready, 0);
    cyc();
    check("grant", current_grant, port);
    check("gv", grant_valid, 1);
    for (int f = 0; f < n; f++) begin
      set_flit(f, f == n - 1);
      credit_return = ret;
      #1;
      check("pkt_ov", out_tvalid, 1);
      check("pkt_data", out_tdata, dat(port, f));
      check("pkt_last", out_tlast, f == n - 1);
      check("pkt_rdy", in_tready, 64'(1) << port);
      cyc();
    end
    credit_return = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_tvalid = '0; in_tdata = '0; in_tlast = '0;
    out_tready = 1'b1; credit_return = 1'b0;
    cyc(); cyc();
    check("rst_gv", grant_valid, 0);
    check("rst_grant", current_grant, 0);
    check("rst_credits", credits_available, 4);
    check("rst_ovf", credit_overflow, 0);
    check("rst_rdy", in_tready, 0);
    check("rst_ov", out_tvalid, 0);
    rst_n = 1'b1;

    // 3-flit packet on port 2, no credit returns
    pkt(2, 3, 1'b0, 5'b00100);
    in_tvalid = '0;
    check("p2_credits", credits_available, 1);
    check("p2_idle", grant_valid, 0);
    credit_return = 1'b1;
    cyc(); cyc(); cyc();
    credit_return = 1'b0;
    check("refill", credits_available, 4);
    check("refill_ovf", credit_overflow, 0);

    // rr_ptr=3: port 4 wins over port 0
    pkt(4, 1, 1'b1, 5'b10001);
    check("p4_credits", credits_available, 4);

    // Fairness across ports 0,1,4
    for (int r = 0; r < 2; r++) begin
      pkt(0, 2, 1'b1, 5'b10011);
      pkt(1, 2, 1'b1, 5'b10011);
      pkt(4, 2, 1'b1, 5'b10011);
    end
    in_tvalid = '0;
    check("rr_credits", credits_available, 4);

    // Credit stall: 6-flit packet on port 3 with 4 credits
    in_tvalid = 5'b01000;
    set_flit(0, 1'b0);
    #1;
    cyc();
    check("p3_grant", current_grant, 3);
    for (int f = 0; f < 4; f++) begin
      set_flit(f, 1'b0);
      #1;
      check("p3_ov", out_tvalid, 1);
      check("p3_data", out_tdata, dat(3, f));
      cyc();
    end
    check("p3_empty", credits_available, 0);
    set_flit(4, 1'b0);
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_ov", out_tvalid, 0);
      check("stall_rdy", in_tready, 0);
      check("stall_gv", grant_valid, 1);
      check("stall_grant", current_grant, 3);
      cyc();
    end
    credit_return = 1'b1;
    #1;
    check("ret_ov", out_tvalid, 0);
    cyc();
    check("ret_credits", credits_available, 1);
    check("resume_ov", out_tvalid, 1);
    check("resume_data", out_tdata, dat(3, 4));
    cyc();
    set_flit(5, 1'b1);
    #1;
    check("p3_last_ov", out_tvalid, 1);
    check("p3_last", out_tlast, 1);
    cyc();
    credit_return = 1'b0;
    in_tvalid = '0;
    check("p3_done_gv", grant_valid, 0);
    check("p3_done_cr", credits_available, 1);

    // Simultaneous transfer and return at C=2, then overflow at C=4
    credit_return = 1'b1;
    cyc();
    credit_return = 1'b0;
    check("c2", credits_available, 2);
    pkt(0, 1, 1'b1, 5'b00001);
    in_tvalid = '0;
    check("same_cycle", credits_available, 2);
    credit_return = 1'b1;
    cyc(); cyc();
    check("c4", credits_available, 4);
    check("no_ovf_yet", credit_overflow, 0);
    cyc();
    credit_return = 1'b0;
    check("ovf_hold", credits_available, 4);
    check("ovf_set", credit_overflow, 1);
    cyc(); cyc();
    check("ovf_sticky", credit_overflow, 1);

    // in_tvalid[1] drops mid-packet while port 0 requests
    in_tvalid = 5'b00011;
    set_flit(0, 1'b0);
    #1;
    cyc();
    check("p1_grant", current_grant, 1);
    credit_return = 1'b1;
    #1;
    check("p1_f0", out_tdata, dat(1, 0));
    cyc();
    credit_return = 1'b0;
    in_tvalid = 5'b00001;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("drop_ov", out_tvalid, 0);
      check("drop_grant", current_grant, 1);
      check("drop_rdy", in_tready, 5'b00010);
      cyc();
    end
    in_tvalid = 5'b00011;
    set_flit(1, 1'b0);
    credit_return = 1'b1;
    #1;
    check("p1_f1", out_tdata, dat(1, 1));
    cyc();
    set_flit(2, 1'b1);
    #1;
    check("p1_f2_last", out_tlast, 1);
    cyc();
    credit_return = 1'b0;
    pkt(0, 1, 1'b1, 5'b00001);

    // Reset mid-packet
    in_tvalid = 5'b00011;
    set_flit(0, 1'b0);
    #1;
    cyc();
    check("pre_rst_grant", current_grant, 1);
    #1;
    check("pre_rst_ov", out_tvalid, 1);
    cyc();
    check("pre_rst_cr", credits_available, 3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mid_rst_gv", grant_valid, 0);
    check("mid_rst_cr", credits_available, 4);
    check("mid_rst_rdy", in_tready, 0);
    check("mid_rst_ovf", credit_overflow, 0);
    check("mid_rst_grant", current_grant, 0);
    pkt(0, 1, 1'b1, 5'b00011);
    in_tvalid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
